cla_seq_multiword_adder: RTL and testbench

Sequential wide adder built from one 8-bit carry-lookahead slice, reused over WORDS cycles. Each cycle it generates g/p for one byte, computes the slice carries with flattened lookahead equations, and registers the slice carry-out. That registered carry feeds the next slice's carry_in_0. Valid/ready on both sides; it sits between the operand source and the datapath result consumer.

---
 rtl/cla_seq_pkg.sv | 8 +
 rtl/cla_pg_slice8.sv | 45 ++++
 rtl/cla_seq_multiword_adder.sv | 108 ++++++++++
 tb/tb_cla_seq_multiword_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types for the sequential carry-lookahead multiword adder.
package cla_seq_pkg;
  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  typedef logic [SLICE_W-1:0] slice_t;
endpackage

// File: rtl/cla_pg_slice8.sv
// Combinational 8-bit carry-lookahead slice: g/p generation and flattened
// sum-of-products carries (no carry depends on another computed carry).
module cla_pg_slice8
  import cla_seq_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   carry_in,
  output slice_t sum,
  output logic   c7,
  output logic   c8
);
  slice_t g;
  slice_t p;
  logic [SLICE_W:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_carry
      logic c_bit;
      // c[gi+1] = carry_in&p[gi..0] | OR_k g[k]&p[gi..k+1]
      always_comb begin
        logic acc;
        logic term;
        acc = carry_in;
        for (int m = 0; m <= gi; m++) acc = acc & p[m];
        for (int k = 0; k <= gi; k++) begin
          term = g[k];
          for (int m = k + 1; m <= gi; m++) term = term & p[m];
          acc = acc | term;
        end
        c_bit = acc;
      end
      assign c[gi+1] = c_bit;
    end
  endgenerate

  assign sum = p ^ c[SLICE_W-1:0];
  assign c7  = c[SLICE_W-1];
  assign c8  = c[SLICE_W];
endmodule

// File: rtl/cla_seq_multiword_adder.sv
// Wide adder reusing one 8-bit lookahead slice over WORDS cycles, with
// valid/ready handshakes on operand and result sides.
module cla_seq_multiword_adder
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*8-1:0]     a,
  input  logic [WORDS*8-1:0]     b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*8-1:0]     sum,
  output logic                   cout,
  output logic                   overflow
);
  localparam int W     = WORDS * SLICE_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg, sum_reg;
  logic             carry_reg, cout_reg, overflow_reg;
  logic [IDX_W-1:0] idx_reg;

  slice_t slice_a, slice_b, slice_sum;
  logic   slice_c7, slice_c8;
  logic   accept;
  logic   last_word;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign last_word = (idx_reg == LAST_IDX);

  // Byte mux with constant part-selects keeps indexing in range for any WORDS.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        slice_a = a_reg[k*SLICE_W +: SLICE_W];
        slice_b = b_reg[k*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_pg_slice8 u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .carry_in (carry_reg),
    .sum      (slice_sum),
    .c7       (slice_c7),
    .c8       (slice_c8)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ADD;
      ADD:     if (last_word) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      idx_reg      <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      idx_reg   <= '0;
    end else if (state_reg == ADD) begin
      for (int k = 0; k < WORDS; k++) begin
        if (idx_reg == IDX_W'(k)) sum_reg[k*SLICE_W +: SLICE_W] <= slice_sum;
      end
      carry_reg <= slice_c8;
      if (last_word) begin
        cout_reg     <= slice_c8;
        overflow_reg <= slice_c7 ^ slice_c8;
        idx_reg      <= '0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_cla_seq_multiword_adder.sv
// Randomized self-checking bench: a WORDS=4 and a WORDS=1 instance against
// an arithmetic reference model (x+y+c, sign-rule overflow).
module tb_cla_seq_multiword_adder;
  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [31:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, overflow1;
  logic [7:0]  a1, b1, sum1;

  int pass_cnt  = 0;
  int check_cnt = 0;

  cla_seq_multiword_adder #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  cla_seq_multiword_adder #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns {overflow, cout, sum} for a w-bit addition.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input int w);
    logic [64:0] full;
    logic [63:0] mask, s;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + 65'(c);
    mask = (64'd1 << w) - 64'd1;
    s    = full[63:0] & mask;
    ovf  = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ovf, full[w], s};
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input int hold, input string tag);
    logic [65:0] exp;
    int n;
    exp = ref_add({32'd0, ta}, {32'd0, tb_v}, tc, 32);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    check({tag, "_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, exp[31:0]);
    check({tag, "_cout"}, cout, exp[64]);
    check({tag, "_ovf"}, overflow, exp[65]);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 3);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_res"}, {overflow, cout, sum}, {exp[65], exp[64], exp[31:0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_consumed"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
    $display("W4 %s a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d ovf=%0d", tag, ta, tb_v, tc,
             exp[31:0], exp[64], exp[65]);
  endtask

  task automatic run_op1(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input string tag);
    logic [65:0] exp;
    int n;
    exp = ref_add({56'd0, ta}, {56'd0, tb_v}, tc, 8);
    check({tag, "_in_ready"}, in_ready1, 1);
    a1 = ta; b1 = tb_v; cin1 = tc; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 8'($urandom);
    n = 0;
    while (!out_valid1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, 1);
    check({tag, "_res"}, {overflow1, cout1, sum1}, {exp[65], exp[64], exp[7:0]});
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({tag, "_idle"}, in_ready1, 1);
    $display("W1 %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d", tag, ta, tb_v, tc,
             exp[7:0], exp[64], exp[65]);
  endtask

  initial begin
    logic [65:0] e1, e2;
    int n;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {overflow, cout, sum}, 0);
    check("rst_w1", {in_ready1, out_valid1, overflow1, cout1, sum1}, {1'b1, 11'd0});
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "wrap");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "ovf");
    run_op(32'h12345678, 32'h0000000F, 1'b1, 0, "cin");
    run_op(32'h80000000, 32'h80000000, 1'b0, 10, "backpressure");

    // Abort while byte 2 is being processed.
    a = 32'hDEADBEEF; b = 32'h11111111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {out_valid, overflow, cout, sum}, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_no_valid", n, 0);
    $display("W4 reset-abort a=deadbeef b=11111111 discarded");
    run_op(32'h00000003, 32'h00000004, 1'b0, 0, "after_rst");

    // Back-to-back with in_valid held high across both operations.
    e1 = ref_add(64'h89ABCDEF, 64'h76543210, 1'b0, 32);
    e2 = ref_add(64'h00FF00FF, 64'hFF00FF01, 1'b0, 32);
    a = 32'h89ABCDEF; b = 32'h76543210; cin = 0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h00FF00FF; b = 32'hFF00FF01;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("b2b_first_sum", sum, e1[31:0]);
    repeat (2) begin
      @(negedge clk);
      check("b2b_held_off", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_accepted", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("b2b_second_sum", {cout, sum}, {e2[64], e2[31:0]});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("W4 b2b first=%08h second=%08h", e1[31:0], e2[31:0]);

    for (int i = 0; i < 1000; i++)
      run_op($urandom, $urandom, 1'($urandom), 0, "rand");

    run_op1(8'hFF, 8'h01, 1'b0, "w1_wrap");
    run_op1(8'h7F, 8'h01, 1'b0, "w1_ovf");
    for (int i = 0; i < 1000; i++)
      run_op1(8'($urandom), 8'($urandom), 1'($urandom), "w1_rand");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
